// File: rtl/draw_axi_pkg.sv
// Shared AXI encodings and FSM state types for the draw-engine VRAM slave.
package draw_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/draw_vram_slave_if.sv
// AXI4 bus bundle between the draw engine (master) and the VRAM slave.
interface draw_vram_slave_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32
);
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/draw_vram_dpram.sv
// Simple dual-port block RAM: byte-enabled write port A, registered
// read-first read port B with a read enable so the output can be held.
module draw_vram_dpram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic                clk_i,
    input  logic [DATA_W/8-1:0] a_we_i,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W-1:0]   a_wdata_i,
    input  logic                b_en_i,
    input  logic [ADDR_W-1:0]   b_addr_i,
    output logic [DATA_W-1:0]   b_rdata_o
);
    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] b_rdata_q;

    // Port A: write only the byte lanes whose enable is set.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BYTES; i++) begin
            if (a_we_i[i]) begin
                mem_q[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
            end
        end
    end

    // Port B: registered read; a same-cycle write to the same word is not seen (read-first).
    always_ff @(posedge clk_i) begin
        if (b_en_i) begin
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/draw_vram_slave.sv
// AXI4 slave backed by on-chip RAM: independent write and read burst FSMs.
// Out-of-range / unsupported bursts complete normally but with SLVERR.
module draw_vram_slave
    import draw_axi_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_WORDS_LOG2   = 14,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    draw_vram_slave_if.slave s_axi
);
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W = C_MEM_WORDS_LOG2 + 1;
    localparam int BYTES = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [AW:0] DEPTH = {{AW{1'b0}}, 1'b1} << C_MEM_WORDS_LOG2;

    // A burst is bad if it starts below the base, uses a size other than
    // 4 bytes, or its last beat lands at or beyond the memory depth.
    function automatic logic burst_bad(input logic [AW-1:0] addr,
                                       input logic [2:0]    size,
                                       input logic [7:0]    len);
        logic [AW:0] last_word;
        last_word = {1'b0, (addr - C_BASE_ADDR) >> 2} + {{(AW-7){1'b0}}, len};
        return (addr < C_BASE_ADDR) || (size != SIZE_4B) || (last_word >= DEPTH);
    endfunction

    // Word index keeps one extra bit so running past the depth is visible.
    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] addr);
        return IDX_W'((addr - C_BASE_ADDR) >> 2);
    endfunction

    // ---------------- write channel state ----------------
    wr_state_e                   w_state_q, w_state_d;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [7:0]                  w_len_q, w_len_d;
    logic [7:0]                  w_beat_q, w_beat_d;
    logic [IDX_W-1:0]            w_idx_q, w_idx_d;
    logic                        w_err_q, w_err_d;
    logic [1:0]                  w_resp_q, w_resp_d;
    logic [BYTES-1:0]            ram_we;

    // ---------------- read channel state ----------------
    rd_state_e                   r_state_q, r_state_d;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id_q, r_id_d;
    logic [7:0]                  r_len_q, r_len_d;
    logic [7:0]                  r_beat_q, r_beat_d;
    logic [IDX_W-1:0]            r_idx_q, r_idx_d;
    logic                        r_err_q, r_err_d;
    logic                        r_valid_q, r_valid_d;
    logic                        ram_rd_req;
    logic [IDX_W-1:0]            ram_rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata;

    // Burst type is always treated as INCR.
    logic unused_ok;
    assign unused_ok = ^{s_axi.awburst, s_axi.arburst};

    // Write FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_idx_q   <= '0;
            w_err_q   <= 1'b0;
            w_resp_q  <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_idx_q   <= w_idx_d;
            w_err_q   <= w_err_d;
            w_resp_q  <= w_resp_d;
        end
    end

    // Write FSM: latch AW, store beats until WLAST or the last counted beat, then respond.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_idx_d   = w_idx_q;
        w_err_d   = w_err_q;
        w_resp_d  = w_resp_q;
        ram_we    = '0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi.awvalid) begin
                    w_id_d    = s_axi.awid;
                    w_len_d   = s_axi.awlen;
                    w_beat_d  = '0;
                    w_idx_d   = word_idx(s_axi.awaddr);
                    w_err_d   = burst_bad(s_axi.awaddr, s_axi.awsize, s_axi.awlen);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi.wvalid) begin
                    // Bad bursts are still drained beat by beat, but never touch memory.
                    if (!w_err_q && !w_idx_q[IDX_W-1]) begin
                        ram_we = s_axi.wstrb;
                    end
                    w_idx_d  = w_idx_q + IDX_W'(1);
                    w_beat_d = w_beat_q + 8'd1;
                    if (s_axi.wlast || (w_beat_q == w_len_q)) begin
                        w_state_d = W_RESP;
                        // A WLAST that disagrees with the AW length is a protocol error.
                        w_resp_d = (w_err_q || (s_axi.wlast != (w_beat_q == w_len_q)))
                                   ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign s_axi.awready = (w_state_q == W_IDLE) && !rst_i;
    assign s_axi.wready  = (w_state_q == W_DATA);
    assign s_axi.bvalid  = (w_state_q == W_RESP);
    assign s_axi.bid     = w_id_q;
    assign s_axi.bresp   = w_resp_q;

    // Read FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_idx_q   <= '0;
            r_err_q   <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_idx_q   <= r_idx_d;
            r_err_q   <= r_err_d;
            r_valid_q <= r_valid_d;
        end
    end

    // Read FSM: first RAM read the cycle after AR, then prefetch the next
    // word on each R handshake; the RAM is not re-read while stalled.
    always_comb begin
        r_state_d  = r_state_q;
        r_id_d     = r_id_q;
        r_len_d    = r_len_q;
        r_beat_d   = r_beat_q;
        r_idx_d    = r_idx_q;
        r_err_d    = r_err_q;
        r_valid_d  = r_valid_q;
        ram_rd_req = 1'b0;
        ram_rd_idx = r_idx_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi.arvalid) begin
                    r_id_d    = s_axi.arid;
                    r_len_d   = s_axi.arlen;
                    r_beat_d  = '0;
                    r_idx_d   = word_idx(s_axi.araddr);
                    r_err_d   = burst_bad(s_axi.araddr, s_axi.arsize, s_axi.arlen);
                    r_valid_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (!r_valid_q) begin
                    ram_rd_req = 1'b1;
                    r_valid_d  = 1'b1;
                end else if (s_axi.rready) begin
                    if (r_beat_q == r_len_q) begin
                        r_valid_d = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        ram_rd_req = 1'b1;
                        ram_rd_idx = r_idx_q + IDX_W'(1);
                        r_idx_d    = r_idx_q + IDX_W'(1);
                        r_beat_d   = r_beat_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign s_axi.arready = (r_state_q == R_IDLE) && !rst_i;
    assign s_axi.rvalid  = r_valid_q;
    assign s_axi.rid     = r_id_q;
    assign s_axi.rdata   = (r_valid_q && !r_err_q) ? ram_rdata : '0;
    assign s_axi.rresp   = (r_valid_q && r_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.rlast   = r_valid_q && (r_beat_q == r_len_q);

    draw_vram_dpram #(
        .DATA_W (C_S_AXI_DATA_WIDTH),
        .ADDR_W (C_MEM_WORDS_LOG2)
    ) u_ram (
        .clk_i     (clk_i),
        .a_we_i    (ram_we),
        .a_addr_i  (w_idx_q[C_MEM_WORDS_LOG2-1:0]),
        .a_wdata_i (s_axi.wdata),
        .b_en_i    (ram_rd_req && !ram_rd_idx[IDX_W-1]),
        .b_addr_i  (ram_rd_idx[C_MEM_WORDS_LOG2-1:0]),
        .b_rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_draw_vram_slave.sv
// Directed + randomized bench for draw_vram_slave against a word-array VRAM model.
module tb_draw_vram_slave;
    import draw_axi_pkg::*;

    localparam int          ID_W   = 1;
    localparam int          ADDR_W = 32;
    localparam int          LOG2   = 14;
    localparam int          DEPTH  = 1 << LOG2;
    localparam logic [31:0] BASE   = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    draw_vram_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) axi ();

    draw_vram_slave #(
        .C_S_AXI_ID_WIDTH   (ID_W),
        .C_S_AXI_ADDR_WIDTH (ADDR_W),
        .C_S_AXI_DATA_WIDTH (32),
        .C_MEM_WORDS_LOG2   (LOG2),
        .C_BASE_ADDR        (BASE)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .s_axi (axi)
    );

    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model's notion of an erroneous burst, straight from the address rules.
    function automatic bit ref_bad(input logic [31:0] addr, input logic [2:0] size, input int len);
        longint w;
        if (addr < BASE) return 1'b1;
        if (size != SIZE_4B) return 1'b1;
        w = longint'((addr - BASE) >> 2);
        return (w + longint'(len)) >= longint'(DEPTH);
    endfunction

    // Write burst from wq_data/wq_strb; WLAST is raised on beat wlast_at.
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input int wlast_at, input bit gaps, input logic [ID_W-1:0] id);
        bit bad;
        int last;
        int n;
        int w0;
        logic [1:0] exp_resp;
        bad  = ref_bad(addr, size, len);
        last = (wlast_at < len) ? wlast_at : len;
        w0   = bad ? 0 : int'((addr - BASE) >> 2);
        exp_resp = (bad || (wlast_at != len)) ? RESP_SLVERR : RESP_OKAY;
        axi.awid = id; axi.awaddr = addr; axi.awlen = 8'(len);
        axi.awsize = size; axi.awburst = BURST_INCR; axi.awvalid = 1'b1;
        n = 0;
        while (!axi.awready && n < 50) begin tick(); n++; end
        check("aw_ready", 32'(axi.awready), 32'd1);
        tick();
        axi.awvalid = 1'b0;
        for (int i = 0; i <= last; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                axi.wvalid = 1'b0;
                tick();
            end
            axi.wvalid = 1'b1; axi.wdata = wq_data[i]; axi.wstrb = wq_strb[i];
            axi.wlast = (i == wlast_at);
            n = 0;
            while (!axi.wready && n < 50) begin tick(); n++; end
            check("w_ready", 32'(axi.wready), 32'd1);
            if (!bad) begin
                for (int b = 0; b < 4; b++) begin
                    if (wq_strb[i][b]) ref_mem[w0 + i][b*8 +: 8] = wq_data[i][b*8 +: 8];
                end
            end
            tick();
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        axi.bready = 1'b1;
        n = 0;
        while (!axi.bvalid && n < 50) begin tick(); n++; end
        check("b_valid", 32'(axi.bvalid), 32'd1);
        check("aw_busy", 32'(axi.awready), 32'd0);
        check("b_id", 32'(axi.bid), 32'(id));
        check("b_resp", 32'(axi.bresp), 32'(exp_resp));
        $display("WR addr=%h len=%0d size=%0d wlast_at=%0d bresp=%0d", addr, len, size, wlast_at, axi.bresp);
        tick();
        axi.bready = 1'b0;
        check("w_idle_aw", 32'(axi.awready), 32'd1);
        check("w_idle_b", 32'(axi.bvalid), 32'd0);
        wq_data.delete();
        wq_strb.delete();
    endtask

    // Read burst; RREADY high with probability pct percent each cycle.
    task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input int pct, input logic [ID_W-1:0] id);
        bit bad;
        int w0;
        int n;
        int cyc;
        int beat;
        bit prev_stall;
        logic [31:0] prev_data;
        logic [31:0] exp_d;
        bad = ref_bad(addr, size, len);
        w0  = bad ? 0 : int'((addr - BASE) >> 2);
        axi.arid = id; axi.araddr = addr; axi.arlen = 8'(len);
        axi.arsize = size; axi.arburst = BURST_INCR; axi.arvalid = 1'b1;
        n = 0;
        while (!axi.arready && n < 50) begin tick(); n++; end
        check("ar_ready", 32'(axi.arready), 32'd1);
        tick();
        axi.arvalid = 1'b0;
        cyc = 1; beat = 0; prev_stall = 1'b0; prev_data = '0;
        while (beat <= len && cyc < 300) begin
            axi.rready = ($urandom_range(0, 99) < pct);
            if (cyc == 1) check("r_lat_t1", 32'(axi.rvalid), 32'd0);
            if (cyc == 2) check("r_lat_t2", 32'(axi.rvalid), 32'd1);
            if (prev_stall) check("r_stall_hold", axi.rdata, prev_data);
            if (axi.rvalid && axi.rready) begin
                exp_d = bad ? 32'd0 : ref_mem[w0 + beat];
                check("r_data", axi.rdata, exp_d);
                check("r_resp", 32'(axi.rresp), bad ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
                check("r_last", 32'(axi.rlast), 32'(beat == len));
                check("r_id", 32'(axi.rid), 32'(id));
                if (pct == 100) check("r_nobubble", 32'(cyc), 32'(beat + 2));
                beat++;
            end
            prev_stall = axi.rvalid && !axi.rready;
            prev_data  = axi.rdata;
            tick();
            cyc++;
        end
        axi.rready = 1'b0;
        check("r_beats", 32'(beat), 32'(len + 1));
        check("r_idle_ar", 32'(axi.arready), 32'd1);
        check("r_idle_v", 32'(axi.rvalid), 32'd0);
        $display("RD addr=%h len=%0d size=%0d pct=%0d beats=%0d cycles=%0d", addr, len, size, pct, beat, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int n;
        int beats;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", 32'(axi.awready), 32'd0);
        check("rst_arready", 32'(axi.arready), 32'd0);
        check("rst_wready", 32'(axi.wready), 32'd0);
        check("rst_bvalid", 32'(axi.bvalid), 32'd0);
        check("rst_rvalid", 32'(axi.rvalid), 32'd0);
        check("rst_rdata", axi.rdata, 32'd0);
        check("rst_bresp", 32'(axi.bresp), 32'd0);
        check("rst_rlast", 32'(axi.rlast), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_aw", 32'(axi.awready), 32'd1);
        check("post_rst_ar", 32'(axi.arready), 32'd1);

        // 1: basic 4-beat write and readback
        wq_data = '{32'h11, 32'h22, 32'h33, 32'h44};
        wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        axi_write(BASE + 32'h100, 3, SIZE_4B, 3, 1'b0, 1'b1);
        axi_read(BASE + 32'h100, 3, SIZE_4B, 100, 1'b1);

        // 2: partial byte strobes
        wq_data = '{32'h0}; wq_strb = '{4'hF};
        axi_write(BASE + 32'h200, 0, SIZE_4B, 0, 1'b0, 1'b0);
        wq_data = '{32'hAABBCCDD}; wq_strb = '{4'b0101};
        axi_write(BASE + 32'h200, 0, SIZE_4B, 0, 1'b0, 1'b0);
        axi_read(BASE + 32'h200, 0, SIZE_4B, 100, 1'b0);

        // 3: 8-beat read with random back-pressure, then full-rate
        for (int i = 0; i < 8; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
        axi_write(BASE + 32'h300, 7, SIZE_4B, 7, 1'b1, 1'b0);
        axi_read(BASE + 32'h300, 7, SIZE_4B, 40, 1'b0);
        axi_read(BASE + 32'h300, 7, SIZE_4B, 100, 1'b1);

        // 4: early WLAST, then a clean single-beat write
        for (int i = 0; i < 4; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
        axi_write(BASE + 32'h400, 3, SIZE_4B, 2, 1'b0, 1'b0);
        wq_data = '{32'hCAFEF00D}; wq_strb = '{4'hF};
        axi_write(BASE + 32'h500, 0, SIZE_4B, 0, 1'b0, 1'b1);
        axi_read(BASE + 32'h500, 0, SIZE_4B, 100, 1'b1);

        // 5: burst running past the top of memory
        a = BASE + 32'(4 * DEPTH - 4);
        wq_data = '{32'h5A5A_1234}; wq_strb = '{4'hF};
        axi_write(a, 0, SIZE_4B, 0, 1'b0, 1'b0);
        wq_data = '{32'hDEAD_BEEF, 32'hDEAD_BEEF}; wq_strb = '{4'hF, 4'hF};
        axi_write(a, 1, SIZE_4B, 1, 1'b0, 1'b0);
        axi_read(a, 0, SIZE_4B, 100, 1'b0);
        axi_read(a, 1, SIZE_4B, 100, 1'b0);

        // Below-base and wrong-size accesses
        wq_data = '{32'h1}; wq_strb = '{4'hF};
        axi_write(BASE - 32'd4, 0, SIZE_4B, 0, 1'b0, 1'b0);
        axi_read(BASE - 32'd8, 1, SIZE_4B, 100, 1'b0);
        axi_read(BASE + 32'h100, 1, 3'b001, 70, 1'b1);

        // 6: reset in the middle of a read burst
        for (int i = 0; i < 8; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
        axi_write(BASE + 32'h600, 7, SIZE_4B, 7, 1'b0, 1'b0);
        axi.arid = 1'b0; axi.araddr = BASE + 32'h600; axi.arlen = 8'd7;
        axi.arsize = SIZE_4B; axi.arburst = BURST_INCR; axi.arvalid = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        axi.rready = 1'b1;
        beats = 0; n = 0;
        while (beats < 2 && n < 20) begin
            if (axi.rvalid) beats++;
            tick();
            n++;
        end
        check("t6_two_beats", 32'(beats), 32'd2);
        rst = 1'b1;
        #1;
        check("t6_rvalid_async", 32'(axi.rvalid), 32'd0);
        check("t6_arready_rst", 32'(axi.arready), 32'd0);
        tick();
        rst = 1'b0;
        axi.rready = 1'b0;
        tick();
        check("t6_arready_rel", 32'(axi.arready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t6_no_resp", 32'(axi.rvalid), 32'd0);
            tick();
        end
        $display("RST mid-read after %0d beats", beats);
        axi_read(BASE + 32'h600, 7, SIZE_4B, 100, 1'b0);

        // Randomized traffic over a 64-word region
        for (int i = 0; i < 64; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
        axi_write(BASE + 32'h1000, 63, SIZE_4B, 63, 1'b0, 1'b0);
        for (int t = 0; t < 24; t++) begin
            int start;
            int len;
            int wl;
            logic [2:0] size;
            logic [ID_W-1:0] id;
            start = $urandom_range(0, 56);
            len   = $urandom_range(0, 7);
            size  = ($urandom_range(0, 7) == 0) ? 3'b011 : SIZE_4B;
            id    = ID_W'($urandom_range(0, 1));
            a     = BASE + 32'h1000 + 32'(start * 4);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin
                    wq_data.push_back($urandom);
                    wq_strb.push_back(4'($urandom_range(0, 15)));
                end
                wl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : len;
                axi_write(a, len, size, wl, 1'b1, id);
            end else begin
                axi_read(a, len, size, 60, id);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
